// File: rtl/dpic_mem_master.sv
// Initiator side of the DPI-C memory port: one LSU load/store at a time, issued as rd_*/we_* strobes.
// Optional build macro DPIC_MEM_MISALIGN_TRAP_EN turns misaligned accesses into access faults.
module dpic_mem_master #(
   parameter logic [63:0] MEM_BASE = 64'h0000_0000_8000_0000,
   parameter logic [63:0] MEM_SIZE = 64'h0000_0000_0800_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic        req_signed,
   input  logic [63:0] req_addr,
   input  logic [63:0] req_wdata,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [63:0] resp_rdata,
   output logic        resp_err,
   output logic        rd_en,
   output logic [63:0] rd_addr,
   input  logic [63:0] rd_data,
   output logic        we_en,
   output logic [63:0] we_addr,
   output logic [63:0] we_data,
   output logic [7:0]  we_mask
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_RESP  = 2'd3
   } state_e;

   state_e      state_q, state_d;
   logic        we_q, we_d;
   logic [1:0]  size_q, size_d;
   logic        signed_q, signed_d;
   logic [63:0] addr_q, addr_d;
   logic [63:0] wdata_q, wdata_d;
   logic        err_q, err_d;
   logic [63:0] rdata_q, rdata_d;
   logic        accept_s;
   logic        fault_s;

   function automatic logic [7:0] size_mask(input logic [1:0] size);
      logic [7:0] m;
      case (size)
         2'd0:    m = 8'h01;
         2'd1:    m = 8'h03;
         2'd2:    m = 8'h0F;
         default: m = 8'hFF;
      endcase
      return m;
   endfunction

   function automatic logic [63:0] byte_keep(input logic [1:0] size);
      logic [7:0]  m;
      logic [63:0] k;
      m = size_mask(size);
      k = 64'd0;
      for (int i = 0; i < 8; i++) begin
         k[i*8 +: 8] = {8{m[i]}};
      end
      return k;
   endfunction

   function automatic logic [63:0] load_extend(input logic [63:0] data, input logic [1:0] size,
                                               input logic sgn);
      logic [63:0] r;
      case (size)
         2'd0:    r = {{56{sgn & data[7]}},  data[7:0]};
         2'd1:    r = {{48{sgn & data[15]}}, data[15:0]};
         2'd2:    r = {{32{sgn & data[31]}}, data[31:0]};
         default: r = data;
      endcase
      return r;
   endfunction

`ifdef DPIC_MEM_MISALIGN_TRAP_EN
   function automatic logic [2:0] align_mask(input logic [1:0] size);
      logic [2:0] a;
      case (size)
         2'd0:    a = 3'b000;
         2'd1:    a = 3'b001;
         2'd2:    a = 3'b011;
         default: a = 3'b111;
      endcase
      return a;
   endfunction
`endif

   // The last touched byte is computed in 65 bits so an access near 2^64 cannot wrap into the window.
   function automatic logic access_fault(input logic [63:0] addr, input logic [1:0] size);
      logic [64:0] first_v;
      logic [64:0] last_v;
      logic [64:0] limit_v;
      logic        f;
      first_v = {1'b0, addr};
      last_v  = first_v + (65'd1 << size) - 65'd1;
      limit_v = {1'b0, MEM_BASE} + {1'b0, MEM_SIZE};
      f = (first_v < {1'b0, MEM_BASE}) || (last_v >= limit_v);
`ifdef DPIC_MEM_MISALIGN_TRAP_EN
      f = f | (|(addr[2:0] & align_mask(size)));
`else
      f = f | 1'b0;
`endif
      return f;
   endfunction

   assign accept_s = req_valid & (state_q == S_IDLE);
   assign fault_s  = access_fault(req_addr, req_size);

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Transaction latches and captured response
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         we_q     <= 1'b0;
         size_q   <= 2'd0;
         signed_q <= 1'b0;
         addr_q   <= 64'd0;
         wdata_q  <= 64'd0;
         err_q    <= 1'b0;
         rdata_q  <= 64'd0;
      end else begin
         we_q     <= we_d;
         size_q   <= size_d;
         signed_q <= signed_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         err_q    <= err_d;
         rdata_q  <= rdata_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (accept_s) begin
               state_d = fault_s ? S_RESP : S_ISSUE;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_ISSUE: begin
            if (we_q) begin
               state_d = S_RESP;
            end else begin
               state_d = S_WAIT;
            end
         end
         S_WAIT: state_d = S_RESP;
         S_RESP: begin
            if (resp_ready) begin
               state_d = S_IDLE;
            end else begin
               state_d = S_RESP;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Latch the request on acceptance; capture extended read data while waiting
   always_comb begin
      we_d     = we_q;
      size_d   = size_q;
      signed_d = signed_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      err_d    = err_q;
      rdata_d  = rdata_q;
      if (accept_s) begin
         we_d     = req_we;
         size_d   = req_size;
         signed_d = req_signed;
         addr_d   = req_addr;
         wdata_d  = req_wdata;
         err_d    = fault_s;
         rdata_d  = 64'd0;
      end else if (state_q == S_WAIT) begin
         rdata_d  = load_extend(rd_data, size_q, signed_q);
      end else begin
         rdata_d  = rdata_q;
      end
   end

   // Output decode: strobes and their payloads only exist in ISSUE
   always_comb begin
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      resp_rdata = 64'd0;
      resp_err   = 1'b0;
      rd_en      = 1'b0;
      rd_addr    = 64'd0;
      we_en      = 1'b0;
      we_addr    = 64'd0;
      we_data    = 64'd0;
      we_mask    = 8'h00;
      case (state_q)
         S_IDLE:  req_ready = 1'b1;
         S_ISSUE: begin
            if (we_q) begin
               we_en   = 1'b1;
               we_addr = addr_q;
               we_data = wdata_q & byte_keep(size_q);
               we_mask = size_mask(size_q);
            end else begin
               rd_en   = 1'b1;
               rd_addr = addr_q;
            end
         end
         S_WAIT:  req_ready = 1'b0;
         S_RESP: begin
            resp_valid = 1'b1;
            resp_rdata = rdata_q;
            resp_err   = err_q;
         end
         default: req_ready = 1'b0;
      endcase
   end

endmodule

// File: tb/tb_dpic_mem_master.sv
// Directed bench for dpic_mem_master: a one-word memory model answers reads, strobes are logged.
module tb_dpic_mem_master;

   logic        clk;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [1:0]  req_size;
   logic        req_signed;
   logic [63:0] req_addr;
   logic [63:0] req_wdata;
   logic        resp_valid;
   logic        resp_ready;
   logic [63:0] resp_rdata;
   logic        resp_err;
   logic        rd_en;
   logic [63:0] rd_addr;
   logic [63:0] rd_data;
   logic        we_en;
   logic [63:0] we_addr;
   logic [63:0] we_data;
   logic [7:0]  we_mask;

   int          checks_cnt   = 0;
   int          failures_cnt = 0;
   logic [63:0] mem_q        = 64'd0;
   int          rd_cnt       = 0;
   int          we_cnt       = 0;
   logic [63:0] rd_addr_seen = 64'd0;
   logic [63:0] we_addr_seen = 64'd0;
   logic [63:0] we_data_seen = 64'd0;
   logic [7:0]  we_mask_seen = 8'h00;

   dpic_mem_master dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_size   (req_size),
      .req_signed (req_signed),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_rdata (resp_rdata),
      .resp_err   (resp_err),
      .rd_en      (rd_en),
      .rd_addr    (rd_addr),
      .rd_data    (rd_data),
      .we_en      (we_en),
      .we_addr    (we_addr),
      .we_data    (we_data),
      .we_mask    (we_mask)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory model: read data appears the cycle after rd_en is sampled; strobes are logged
   always @(posedge clk) begin
      if (rd_en) begin
         rd_cnt       <= rd_cnt + 1;
         rd_addr_seen <= rd_addr;
         rd_data      <= mem_q;
      end
      if (we_en) begin
         we_cnt       <= we_cnt + 1;
         we_addr_seen <= we_addr;
         we_data_seen <= we_data;
         we_mask_seen <= we_mask;
      end
   end

   task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks_cnt++;
      if (act !== exp) begin
         failures_cnt++;
         $display("FAIL %s: got 0x%016h expected 0x%016h", tag, act, exp);
      end
   endtask

   // Offer one request, scramble the inputs after acceptance, then check the response.
   task automatic run_req(input string tag, input logic we, input logic [1:0] size, input logic sgn,
                          input logic [63:0] addr, input logic [63:0] wdata, input int exp_lat,
                          input logic exp_err, input logic [63:0] exp_rdata, input int exp_rd,
                          input int exp_we, input bit finish);
      int rd0;
      int we0;
      int lat;
      rd0 = rd_cnt;
      we0 = we_cnt;
      @(negedge clk);
      req_valid  = 1'b1;
      req_we     = we;
      req_size   = size;
      req_signed = sgn;
      req_addr   = addr;
      req_wdata  = wdata;
      check_val({tag, ".req_ready"}, {63'd0, req_ready}, 64'd1);
      @(posedge clk);
      #1;
      req_valid  = 1'b0;
      req_we     = ~we;
      req_size   = ~size;
      req_signed = ~sgn;
      req_addr   = 64'd0;
      req_wdata  = 64'hFFFF_FFFF_FFFF_FFFF;
      lat = 1;
      while (!resp_valid && lat < 8) begin
         @(posedge clk);
         #1;
         lat++;
      end
      check_val({tag, ".latency"}, 64'(lat), 64'(exp_lat));
      check_val({tag, ".resp_err"}, {63'd0, resp_err}, {63'd0, exp_err});
      check_val({tag, ".resp_rdata"}, resp_rdata, exp_rdata);
      check_val({tag, ".rd_count"}, 64'(rd_cnt - rd0), 64'(exp_rd));
      check_val({tag, ".we_count"}, 64'(we_cnt - we0), 64'(exp_we));
      if (finish) begin
         resp_ready = 1'b1;
         @(posedge clk);
         #1;
         resp_ready = 1'b0;
         check_val({tag, ".after_hs"}, {62'd0, resp_valid, req_ready}, 64'd1);
      end
   endtask

   initial begin
      int rd_before;
      int we_before;
      rst_n      = 1'b1;
      req_valid  = 1'b0;
      req_we     = 1'b0;
      req_size   = 2'd0;
      req_signed = 1'b0;
      req_addr   = 64'd0;
      req_wdata  = 64'd0;
      resp_ready = 1'b0;
      #1 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_val("rst.strobes", {60'd0, rd_en, we_en, resp_valid, resp_err}, 64'd0);
      check_val("rst.payload", rd_addr | we_addr | we_data | resp_rdata | {56'd0, we_mask}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check_val("rst.req_ready", {63'd0, req_ready}, 64'd1);

      // Signed byte load
      mem_q = 64'h0123_4567_89AB_CD80;
      run_req("lb_s", 1'b0, 2'd0, 1'b1, 64'h8000_0003, 64'd0, 3, 1'b0, 64'hFFFF_FFFF_FFFF_FF80, 1, 0, 1'b1);
      check_val("lb_s.rd_addr", rd_addr_seen, 64'h8000_0003);

      // Half store: upper bytes cleared, mask 03
      run_req("sh", 1'b1, 2'd1, 1'b0, 64'h8000_0010, 64'h1234_5678_9ABC_DEF0, 2, 1'b0, 64'd0, 0, 1, 1'b1);
      check_val("sh.we_addr", we_addr_seen, 64'h8000_0010);
      check_val("sh.we_data", we_data_seen, 64'h0000_0000_0000_DEF0);
      check_val("sh.we_mask", {56'd0, we_mask_seen}, 64'h03);

      // Window faults
      run_req("ld_below", 1'b0, 2'd3, 1'b0, 64'h7FFF_FFF8, 64'd0, 1, 1'b1, 64'd0, 0, 0, 1'b1);
      run_req("lw_end",   1'b0, 2'd2, 1'b0, 64'h87FF_FFFE, 64'd0, 1, 1'b1, 64'd0, 0, 0, 1'b1);
      run_req("lb_top",   1'b0, 2'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1, 1'b1, 64'd0, 0, 0, 1'b1);
      run_req("lb_limit", 1'b0, 2'd0, 1'b0, 64'h8800_0000, 64'd0, 1, 1'b1, 64'd0, 0, 0, 1'b1);
      mem_q = 64'h0000_0000_0000_007F;
      run_req("lb_last",  1'b0, 2'd0, 1'b1, 64'h87FF_FFFF, 64'd0, 3, 1'b0, 64'h7F, 1, 0, 1'b1);

      // Misaligned word load
      mem_q = 64'h1122_3344_8899_AABB;
`ifdef DPIC_MEM_MISALIGN_TRAP_EN
      run_req("lw_mis", 1'b0, 2'd2, 1'b0, 64'h8000_0002, 64'd0, 1, 1'b1, 64'd0, 0, 0, 1'b1);
`else
      run_req("lw_mis", 1'b0, 2'd2, 1'b0, 64'h8000_0002, 64'd0, 3, 1'b0, 64'h0000_0000_8899_AABB, 1, 0, 1'b1);
      check_val("lw_mis.rd_addr", rd_addr_seen, 64'h8000_0002);
`endif

      // Extension variants
      mem_q = 64'h5555_5555_5555_F234;
      run_req("lh_s", 1'b0, 2'd1, 1'b1, 64'h8000_0020, 64'd0, 3, 1'b0, 64'hFFFF_FFFF_FFFF_F234, 1, 0, 1'b1);
      run_req("lh_u", 1'b0, 2'd1, 1'b0, 64'h8000_0020, 64'd0, 3, 1'b0, 64'h0000_0000_0000_F234, 1, 0, 1'b1);
      mem_q = 64'h1111_1111_8765_4321;
      run_req("lw_s", 1'b0, 2'd2, 1'b1, 64'h8000_0004, 64'd0, 3, 1'b0, 64'hFFFF_FFFF_8765_4321, 1, 0, 1'b1);
      mem_q = 64'hFFFF_FFFF_FFFF_FFF0;
      run_req("lb_u", 1'b0, 2'd0, 1'b0, 64'h8000_0005, 64'd0, 3, 1'b0, 64'h0000_0000_0000_00F0, 1, 0, 1'b1);

      // Store widths, including the last legal dword
      run_req("sd", 1'b1, 2'd3, 1'b0, 64'h87FF_FFF8, 64'hAAAA_BBBB_CCCC_DDDD, 2, 1'b0, 64'd0, 0, 1, 1'b1);
      check_val("sd.we_data", we_data_seen, 64'hAAAA_BBBB_CCCC_DDDD);
      check_val("sd.we_mask", {56'd0, we_mask_seen}, 64'hFF);
      run_req("sw", 1'b1, 2'd2, 1'b0, 64'h8000_0040, 64'hFFFF_FFFF_1234_5678, 2, 1'b0, 64'd0, 0, 1, 1'b1);
      check_val("sw.we_data", we_data_seen, 64'h0000_0000_1234_5678);
      check_val("sw.we_mask", {56'd0, we_mask_seen}, 64'h0F);
      run_req("sb", 1'b1, 2'd0, 1'b0, 64'h8000_0041, 64'h9999_9999_9999_99A5, 2, 1'b0, 64'd0, 0, 1, 1'b1);
      check_val("sb.we_data", we_data_seen, 64'h0000_0000_0000_00A5);
      check_val("sb.we_addr", we_addr_seen, 64'h8000_0041);

      // Back-pressure: response held for 5 cycles while a new request is offered
      mem_q = 64'hDEAD_BEEF_CAFE_F00D;
      run_req("ld_hold", 1'b0, 2'd3, 1'b0, 64'h8000_0100, 64'd0, 3, 1'b0, 64'hDEAD_BEEF_CAFE_F00D, 1, 0, 1'b0);
      rd_before = rd_cnt;
      req_valid = 1'b1;
      req_we    = 1'b0;
      req_addr  = 64'h8000_0200;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         check_val("hold.valid_ready", {62'd0, resp_valid, req_ready}, 64'd2);
         check_val("hold.rdata", resp_rdata, 64'hDEAD_BEEF_CAFE_F00D);
      end
      check_val("hold.no_strobe", 64'(rd_cnt - rd_before), 64'd0);
      req_valid  = 1'b0;
      resp_ready = 1'b1;
      @(posedge clk);
      #1;
      resp_ready = 1'b0;
      check_val("hold.released", {62'd0, resp_valid, req_ready}, 64'd1);

      // Reset during the ISSUE cycle of a store
      we_before = we_cnt;
      @(negedge clk);
      req_valid = 1'b1;
      req_we    = 1'b1;
      req_size  = 2'd3;
      req_addr  = 64'h8000_0080;
      req_wdata = 64'h0BAD_0BAD_0BAD_0BAD;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      check_val("rst_mid.we_en_before", {63'd0, we_en}, 64'd1);
      #1 rst_n = 1'b0;
      #1;
      check_val("rst_mid.we_en_drop", {63'd0, we_en}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      check_val("rst_mid.no_resp", {63'd0, resp_valid}, 64'd0);
      check_val("rst_mid.no_write", 64'(we_cnt - we_before), 64'd0);

      // Normal operation after the interrupted transaction
      mem_q = 64'h0F0E_0D0C_0B0A_0908;
      run_req("ld_post", 1'b0, 2'd3, 1'b0, 64'h8000_0008, 64'd0, 3, 1'b0, 64'h0F0E_0D0C_0B0A_0908, 1, 0, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, failures_cnt);
      $finish;
   end

endmodule
